// File: rtl/dice_roll_validator_if.sv
// Roll handoff from dice_roll_validator to the game logic controller.
// The validator drives value/valid; the consumer answers with ready.
interface dice_roll_validator_if;
   logic       roll_valid;
   logic [2:0] roll_value;
   logic       roll_ready;

   modport master (output roll_valid, output roll_value, input roll_ready);
   modport slave  (input roll_valid, input roll_value, output roll_ready);
endinterface

// File: rtl/dice_roll_validator.sv
// Turns noisy pclk-domain colour results into one validated roll per throw:
// arm on a steady white tray, confirm repeated colours, then hand the roll off with valid/ready.
//
// state      | meaning
// IDLE       | game not awaiting a roll; outputs quiet
// WAIT_WHITE | waiting for white (dice removed) to hold WHITE_HOLD_CYC cycles
// ARMED      | tray was clear; first non-white colour result starts a confirm
// CONFIRM    | counting identical colour results, bounded by TIMEOUT_CYC
// PRESENT    | roll_valid high until the consumer accepts
module dice_roll_validator #(
   parameter int CONFIRM_COUNT  = 3,
   parameter int WHITE_HOLD_CYC = 2_000_000,
   parameter int TIMEOUT_CYC    = 500_000_000
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enable,
   input  logic [1:0]                    color_in,
   input  logic                          color_ready,
   input  logic                          white_in,
   dice_roll_validator_if.master         roll,
   output logic                          timeout,
   output logic [2:0]                    state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_WAIT_WHITE = 3'd1,
      S_ARMED      = 3'd2,
      S_CONFIRM    = 3'd3,
      S_PRESENT    = 3'd4
   } state_t;

   localparam int WW = $clog2(WHITE_HOLD_CYC) + 1;
   localparam int MW = $clog2(CONFIRM_COUNT) + 1;
   localparam int TW = $clog2(TIMEOUT_CYC) + 1;

   localparam logic [WW-1:0] WHITE_TC = WW'(WHITE_HOLD_CYC - 1);
   localparam logic [MW-1:0] MATCH_TC = MW'(CONFIRM_COUNT);
   localparam logic [TW-1:0] TIME_TC  = TW'(TIMEOUT_CYC - 1);

   state_t        state_q, state_d;
   logic          cr_s1_q, cr_s2_q, cr_s3_q;
   logic          wh_s1_q, wh_s2_q;
   logic [1:0]    col_s1_q, col_s2_q;
   logic [WW-1:0] white_cnt_q, white_cnt_d;
   logic [MW-1:0] match_cnt_q, match_cnt_d;
   logic [TW-1:0] time_cnt_q, time_cnt_d;
   logic [1:0]    color_q, color_d;
   logic [2:0]    value_q, value_d;
   logic          timeout_q, timeout_d;

   logic          ready_evt;
   logic          white_sync;

   assign ready_evt  = cr_s2_q & ~cr_s3_q;
   assign white_sync = wh_s2_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cr_s1_q     <= 1'b0;
         cr_s2_q     <= 1'b0;
         cr_s3_q     <= 1'b0;
         wh_s1_q     <= 1'b0;
         wh_s2_q     <= 1'b0;
         col_s1_q    <= 2'd0;
         col_s2_q    <= 2'd0;
         white_cnt_q <= '0;
         match_cnt_q <= '0;
         time_cnt_q  <= '0;
         color_q     <= 2'd0;
         value_q     <= 3'd0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cr_s1_q     <= color_ready;
         cr_s2_q     <= cr_s1_q;
         cr_s3_q     <= cr_s2_q;
         wh_s1_q     <= white_in;
         wh_s2_q     <= wh_s1_q;
         col_s1_q    <= color_in;
         col_s2_q    <= col_s1_q;
         white_cnt_q <= white_cnt_d;
         match_cnt_q <= match_cnt_d;
         time_cnt_q  <= time_cnt_d;
         color_q     <= color_d;
         value_q     <= value_d;
         timeout_q   <= timeout_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      white_cnt_d = white_cnt_q;
      match_cnt_d = match_cnt_q;
      time_cnt_d  = time_cnt_q;
      color_d     = color_q;
      value_d     = value_q;
      timeout_d   = 1'b0;
      if (!enable) begin
         // Abort wins over everything, including a roll waiting in PRESENT.
         state_d     = S_IDLE;
         white_cnt_d = '0;
         match_cnt_d = '0;
         time_cnt_d  = '0;
         value_d     = 3'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_d     = S_WAIT_WHITE;
               white_cnt_d = '0;
            end
            S_WAIT_WHITE: begin
               if (!white_sync) begin
                  white_cnt_d = '0;
               end else if (white_cnt_q == WHITE_TC) begin
                  state_d     = S_ARMED;
                  white_cnt_d = '0;
               end else begin
                  white_cnt_d = white_cnt_q + WW'(1);
               end
            end
            S_ARMED: begin
               if (ready_evt && !white_sync) begin
                  color_d     = col_s2_q;
                  match_cnt_d = MW'(1);
                  time_cnt_d  = '0;
                  if (CONFIRM_COUNT == 1) begin
                     state_d = S_PRESENT;
                     value_d = 3'(col_s2_q) + 3'd1;
                  end else begin
                     state_d = S_CONFIRM;
                  end
               end
            end
            S_CONFIRM: begin
               time_cnt_d = time_cnt_q + TW'(1);
               // Priority: timeout, then white (dice lifted), then a colour result.
               if (time_cnt_q == TIME_TC) begin
                  timeout_d   = 1'b1;
                  state_d     = S_WAIT_WHITE;
                  match_cnt_d = '0;
                  time_cnt_d  = '0;
                  white_cnt_d = '0;
               end else if (white_sync) begin
                  state_d     = S_ARMED;
                  match_cnt_d = '0;
               end else if (ready_evt) begin
                  if (col_s2_q == color_q) begin
                     match_cnt_d = match_cnt_q + MW'(1);
                     if (match_cnt_q + MW'(1) == MATCH_TC) begin
                        state_d = S_PRESENT;
                        value_d = 3'(color_q) + 3'd1;
                     end
                  end else begin
                     color_d     = col_s2_q;
                     match_cnt_d = MW'(1);
                  end
               end
            end
            S_PRESENT: begin
               if (roll.roll_ready) begin
                  state_d     = S_WAIT_WHITE;
                  white_cnt_d = '0;
                  match_cnt_d = '0;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      roll.roll_valid = (state_q == S_PRESENT);
      roll.roll_value = value_q;
      timeout         = timeout_q;
      state_dbg       = state_q;
   end

endmodule

// File: tb/tb_dice_roll_validator.sv
// Directed bench for dice_roll_validator: stimulus pushes expected rolls/timeouts,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_dice_roll_validator;
   localparam int CC = 3;
   localparam int WH = 8;
   localparam int TO = 200;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic [1:0] color_in;
   logic       color_ready;
   logic       white_in;
   logic       timeout;
   logic [2:0] state_dbg;

   dice_roll_validator_if rif ();

   dice_roll_validator #(
      .CONFIRM_COUNT (CC),
      .WHITE_HOLD_CYC(WH),
      .TIMEOUT_CYC   (TO)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .color_in   (color_in),
      .color_ready(color_ready),
      .white_in   (white_in),
      .roll       (rif),
      .timeout    (timeout),
      .state_dbg  (state_dbg)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [2:0] exp_q[$];
   int         exp_to   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Colour result held 3 clk wide, then 3 clk low so the next rising edge is clean.
   task automatic pulse(input logic [1:0] c);
      color_in    = c;
      color_ready = 1'b1;
      tick(3);
      color_ready = 1'b0;
      tick(3);
   endtask

   task automatic arm(input string name);
      white_in = 1'b1;
      tick(12);
      check(name, 32'(state_dbg), 32'd2);
      white_in = 1'b0;
      tick(3);
   endtask

   task automatic ack(input string name);
      check({name, "_valid_before_ack"}, 32'(rif.roll_valid), 32'd1);
      rif.roll_ready = 1'b1;
      tick(1);
      rif.roll_ready = 1'b0;
      check({name, "_valid_after_ack"}, 32'(rif.roll_valid), 32'd0);
      check({name, "_state_after_ack"}, 32'(state_dbg), 32'd1);
   endtask

   // Monitor: a rising roll_valid or any timeout cycle consumes one expectation.
   initial begin
      logic pv;
      pv = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            pv = 1'b0;
         end else begin
            if (rif.roll_valid && !pv) begin
               if (exp_q.size() == 0) check("roll_unexpected_q", 32'(exp_q.size()), 32'd1);
               else check("roll_value", 32'(rif.roll_value), 32'(exp_q.pop_front()));
            end
            if (timeout) begin
               check("timeout_expected", 32'(exp_to), 32'd1);
               if (exp_to > 0) exp_to--;
            end
            pv = rif.roll_valid;
         end
      end
   end

   initial begin
      reset          = 1'b1;
      enable         = 1'b0;
      color_in       = 2'd0;
      color_ready    = 1'b0;
      white_in       = 1'b0;
      rif.roll_ready = 1'b0;
      tick(3);
      check("rst_state", 32'(state_dbg), 32'd0);
      check("rst_valid", 32'(rif.roll_valid), 32'd0);
      check("rst_value", 32'(rif.roll_value), 32'd0);
      check("rst_timeout", 32'(timeout), 32'd0);
      reset = 1'b0;
      tick(2);
      check("idle_no_enable", 32'(state_dbg), 32'd0);
      enable = 1'b1;
      tick(1);
      check("enter_wait_white", 32'(state_dbg), 32'd1);

      // Basic roll; arming lands exactly on the 10th edge (2 sync + 8 hold).
      white_in = 1'b1;
      tick(9);
      check("arm_not_early", 32'(state_dbg), 32'd1);
      tick(1);
      check("arm_on_time", 32'(state_dbg), 32'd2);
      white_in = 1'b0;
      tick(3);
      pulse(2'b10);
      pulse(2'b10);
      check("basic_no_valid_at_2", 32'(rif.roll_valid), 32'd0);
      exp_q.push_back(3'd3);
      pulse(2'b10);
      ack("basic");

      // Mismatch restarts the match count.
      arm("mm_armed");
      pulse(2'b01);
      pulse(2'b01);
      pulse(2'b11);
      pulse(2'b11);
      check("mm_no_valid_at_4", 32'(rif.roll_valid), 32'd0);
      exp_q.push_back(3'd4);
      pulse(2'b11);
      ack("mm");

      // White during confirm drops back to ARMED and clears the count.
      arm("wi_armed");
      pulse(2'b00);
      pulse(2'b00);
      white_in = 1'b1;
      tick(3);
      check("wi_back_to_armed", 32'(state_dbg), 32'd2);
      white_in = 1'b0;
      tick(3);
      pulse(2'b00);
      pulse(2'b00);
      check("wi_match_cleared", 32'(rif.roll_valid), 32'd0);
      exp_q.push_back(3'd1);
      pulse(2'b00);
      ack("wi");

      // Timeout: CONFIRM entered at edge E0, timeout registered at E200.
      arm("to_armed");
      exp_to = 1;
      pulse(2'b01);
      tick(196);
      check("to_not_early", 32'(timeout), 32'd0);
      check("to_still_confirm", 32'(state_dbg), 32'd3);
      tick(1);
      check("to_pulse", 32'(timeout), 32'd1);
      check("to_state", 32'(state_dbg), 32'd1);
      tick(1);
      check("to_one_cycle", 32'(timeout), 32'd0);
      check("to_no_valid", 32'(rif.roll_valid), 32'd0);

      // Backpressure then abort.
      arm("bp_armed");
      pulse(2'b10);
      pulse(2'b10);
      exp_q.push_back(3'd3);
      pulse(2'b10);
      repeat (4) pulse(2'b00);
      tick(26);
      check("bp_valid_held", 32'(rif.roll_valid), 32'd1);
      check("bp_value_held", 32'(rif.roll_value), 32'd3);
      check("bp_state", 32'(state_dbg), 32'd4);
      enable = 1'b0;
      tick(1);
      check("abort_valid", 32'(rif.roll_valid), 32'd0);
      check("abort_state", 32'(state_dbg), 32'd0);

      // Arming glitch at hold count 6, then reset from CONFIRM.
      enable = 1'b1;
      tick(1);
      check("gl_wait_white", 32'(state_dbg), 32'd1);
      white_in = 1'b1;
      tick(6);
      white_in = 1'b0;
      tick(1);
      white_in = 1'b1;
      tick(9);
      check("gl_not_armed", 32'(state_dbg), 32'd1);
      tick(1);
      check("gl_armed", 32'(state_dbg), 32'd2);
      white_in = 1'b0;
      tick(3);
      pulse(2'b01);
      check("rs_in_confirm", 32'(state_dbg), 32'd3);
      reset = 1'b1;
      tick(1);
      check("rs_state", 32'(state_dbg), 32'd0);
      check("rs_valid", 32'(rif.roll_valid), 32'd0);
      check("rs_value", 32'(rif.roll_value), 32'd0);
      check("rs_timeout", 32'(timeout), 32'd0);
      reset  = 1'b0;
      enable = 1'b0;
      tick(5);

      check("exp_rolls_drained", 32'(exp_q.size()), 32'd0);
      check("exp_timeouts_drained", 32'(exp_to), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dice_roll_validator.md
Name: dice_roll_validator

Overview:
- Sits between Color_Detector (stable_color / result_ready / current_state_white) and Game_Logic_Controller (dice_valid / dice_value).
- Turns noisy per-frame colour results into exactly one validated roll per throw.
- Arming rule: the tray must show white (dice removed) for a hold time before each throw.
- Confirmation rule: the same colour must repeat CONFIRM_COUNT times before the roll is accepted.
- Hands the roll downstream with a valid/ready handshake.
- Runs on the system clock and synchronises its pclk-domain inputs internally.

Parameters:
- CONFIRM_COUNT, 3: consecutive identical colour results required to accept a roll (≥1).
- WHITE_HOLD_CYC, 2_000_000: clk cycles white must be continuously seen to arm (20 ms at 100 MHz).
- TIMEOUT_CYC, 500_000_000: clk cycles allowed in CONFIRM before abort (5 s).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- enable  input  1  game logic is awaiting a roll; low aborts
- color_in  input  2  stable_color from Color_Detector (pclk domain)
- color_ready  input  1  result_ready pulse from Color_Detector (pclk domain, ≥2 clk wide)
- white_in  input  1  current_state_white level (pclk domain)
- roll_valid  output  1  validated roll available
- roll_value  output  3  steps 1..4 (= color + 1)
- roll_ready  input  1  consumer accepts roll
- timeout  output  1  one-cycle pulse on confirm timeout
- state_dbg  output  3  current FSM state encoding

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high. All flops reset on posedge clk when reset=1.
- Reset values: roll_valid=0, roll_value=0, timeout=0, state=IDLE (state_dbg=0), all counters 0, synchroniser flops 0.
- Input synchronisation:
  - color_ready and white_in each pass through 2 flops.
  - ready event = rising edge of synced color_ready (needs a 3rd flop).
  - color_in is captured through 2 flops and sampled only on a ready event.
  - Event is detected 3 clk after the input rises.
- States (state_dbg): IDLE=0, WAIT_WHITE=1, ARMED=2, CONFIRM=3, PRESENT=4.
- IDLE:
  - outputs 0.
  - enable=1 → WAIT_WHITE.
- WAIT_WHITE:
  - white_cnt increments while white_sync=1 and clears on white_sync=0.
  - white_cnt reaching WHITE_HOLD_CYC-1 with white still high → ARMED.
- ARMED:
  - ready event while white_sync=0 → capture colour, match_cnt=1, timeout_cnt=0, → CONFIRM.
  - If CONFIRM_COUNT=1, go directly to PRESENT instead.
  - Ready events while white_sync=1 are ignored.
- CONFIRM:
  - timeout_cnt increments every cycle.
  - Ready event with the same colour → match_cnt+1. Reaching CONFIRM_COUNT → latch roll_value=colour+1 and go to PRESENT; roll_valid=1 the next cycle.
  - Ready event with a different colour → captured colour replaced, match_cnt=1, timeout_cnt unchanged.
  - white_sync=1 → ARMED, match_cnt cleared.
  - timeout_cnt reaching TIMEOUT_CYC-1 → timeout=1 for one cycle, → WAIT_WHITE.
  - Simultaneous events: timeout has priority over white, and white over a ready event.
- PRESENT:
  - roll_valid=1; roll_value held stable.
  - roll_valid & roll_ready at a clk edge → roll_valid=0 next cycle, → WAIT_WHITE. A new throw therefore requires the dice to be removed first.
  - roll_ready when roll_valid=0 has no effect.
  - Ready events in PRESENT are ignored.
- enable=0 in any state (including PRESENT) → IDLE next cycle. roll_valid and counters are cleared and any pending roll is dropped. enable has priority over all other transitions.
- Reset mid-operation returns to IDLE regardless of handshake state.
- Counter widths: $clog2 of each parameter +1, with no wrap. Counters saturate by construction because the state exits at the terminal count.

Test Plan:
(Params for all scenarios: CONFIRM_COUNT=3, WHITE_HOLD_CYC=8, TIMEOUT_CYC=200.)
- Basic roll: enable=1; white_in=1 for 8+ cycles → state_dbg=2. Then white_in=0 and three ready pulses with color_in=2'b10 → roll_valid=1, roll_value=3. Pulse roll_ready → roll_valid=0 and state_dbg=1.
- Mismatch restart: ready pulses with colours 01, 01, 11, 11, 11 → no valid after the first two; valid after the fifth with roll_value=4.
- White interrupt: two matching pulses, then white_in=1 → state_dbg=2 and match count cleared. Three fresh pulses of 00 → roll_value=1.
- Timeout: enter CONFIRM with one pulse, no further pulses → timeout pulses exactly once 200 cycles later, state_dbg=1, roll_valid stays 0.
- Backpressure and abort: roll_valid held with roll_ready=0 for 50 cycles → value stable and extra ready pulses ignored. Then enable=0 → roll_valid=0 next cycle, state_dbg=0.
- Arming glitch and reset: white_in drops for 1 cycle at hold count 6 → arming takes a further 8 cycles. A reset asserted in CONFIRM → all outputs 0, state_dbg=0 next cycle.
